irq_controller: RTL and testbench

//  Parametrised interrupt controller; supersedes the combinational IF-update path.

---
 rtl/irq_controller.sv | 118 +++++++++++
 tb/tb_irq_controller.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Interrupt controller: owns IF/IE, edge-detects level sources, and presents one
// prioritised request and vector to the CPU through a req/ack handshake.
module irq_controller #(
  parameter int          NUM_SRC    = 5,
  parameter logic [15:0] IF_ADDR    = 16'hFF0F,
  parameter logic [15:0] IE_ADDR    = 16'hFFFF,
  parameter logic [15:0] VEC_BASE   = 16'h0040,
  parameter int          VEC_STRIDE = 8
) (
  input  logic               clk_5MHz,
  input  logic               Reset,
  input  logic [NUM_SRC-1:0] src_level,
  input  logic [15:0]        cpu_addr,
  input  logic [7:0]         cpu_wdata,
  output logic [7:0]         cpu_rdata,
  input  logic               cpu_we,
  input  logic               cpu_re,
  input  logic               ime,
  input  logic               irq_ack,
  output logic               irq_req,
  output logic [15:0]        irq_vector,
  output logic               wake,
  output logic [1:0]         fsm_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [NUM_SRC-1:0] if_q;
  logic [NUM_SRC-1:0] if_next;
  logic [NUM_SRC-1:0] src_prev;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] sel_onehot;
  logic [7:0]         ie_q;
  logic [1:0]         state;
  logic [2:0]         sel;
  logic [2:0]         sel_q;
  logic               if_hit;
  logic               ie_hit;
  logic               ack_clr;

  assign if_hit     = (cpu_addr == IF_ADDR);
  assign ie_hit     = (cpu_addr == IE_ADDR);
  assign rise       = src_level & ~src_prev;
  assign pending    = if_q & ie_q[NUM_SRC-1:0];
  assign sel_onehot = NUM_SRC'(1) << sel_q;
  assign wake       = |pending;
  assign fsm_state  = state;

  // Handshake: irq_req holds with a stable irq_vector until the CPU pulses
  // irq_ack for one cycle; the transfer happens on the cycle both are high.
  assign ack_clr = (state == ST_REQ) && irq_ack;

  // Lowest set bit wins; scanning downward leaves the lowest index last.
  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i]) sel = 3'(i);
    end
  end

  // Per-bit precedence: hardware rise over CPU write over ack clear.
  always_comb begin
    if_next = if_q & ~(ack_clr ? sel_onehot : '0);
    if (cpu_we && if_hit) if_next = cpu_wdata[NUM_SRC-1:0];
    if_next = if_next | rise;
  end

  always_comb begin
    cpu_rdata = 8'hFF;
    if (cpu_re && if_hit)      cpu_rdata[NUM_SRC-1:0] = if_q;
    else if (cpu_re && ie_hit) cpu_rdata = ie_q;
  end

  always_ff @(posedge clk_5MHz) begin
    if (Reset) begin
      if_q       <= '0;
      ie_q       <= '0;
      src_prev   <= '0;
      state      <= ST_IDLE;
      sel_q      <= '0;
      irq_req    <= 1'b0;
      irq_vector <= VEC_BASE;
    end else begin
      src_prev <= src_level;
      if_q     <= if_next;
      if (cpu_we && ie_hit) ie_q <= cpu_wdata;
      case (state)
        ST_IDLE: begin
          if (ime && (|pending)) begin
            sel_q      <= sel;
            irq_vector <= VEC_BASE + 16'(VEC_STRIDE) * {13'd0, sel};
            irq_req    <= 1'b1;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            irq_req <= 1'b0;
            state   <= ST_GAP;
          end else if (!(|(pending & sel_onehot))) begin
            // Software withdrew the latched source before the CPU took it.
            irq_req <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        ST_GAP:  state <= ST_IDLE;
        default: begin
          irq_req <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_irq_controller;

  localparam int          NS   = 5;
  localparam logic [15:0] IF_A = 16'hFF0F;
  localparam logic [15:0] IE_A = 16'hFFFF;
  localparam logic [15:0] VB   = 16'h0040;
  localparam int          VS   = 8;

  logic          clk_5MHz = 1'b0;
  logic          Reset    = 1'b1;
  logic [NS-1:0] src_level = '0;
  logic [15:0]   cpu_addr  = '0;
  logic [7:0]    cpu_wdata = '0;
  logic [7:0]    cpu_rdata;
  logic          cpu_we  = 1'b0;
  logic          cpu_re  = 1'b0;
  logic          ime     = 1'b0;
  logic          irq_ack = 1'b0;
  logic          irq_req;
  logic [15:0]   irq_vector;
  logic          wake;
  logic [1:0]    fsm_state;

  int n_tests = 0;
  int n_fail  = 0;

  irq_controller dut (
    .clk_5MHz  (clk_5MHz),
    .Reset     (Reset),
    .src_level (src_level),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .ime       (ime),
    .irq_ack   (irq_ack),
    .irq_req   (irq_req),
    .irq_vector(irq_vector),
    .wake      (wake),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / watchdog ----------------
  always #100 clk_5MHz = ~clk_5MHz;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_REQ, M_GAP} phase_t;
  phase_t        m_ph = M_IDLE;
  logic [NS-1:0] m_if = '0, m_prev = '0;
  logic [7:0]    m_ie = '0;
  logic          m_req = 1'b0;
  logic [15:0]   m_vec = VB;
  int            m_sel = 0;
  bit            m_valid = 1'b0;
  logic [15:0]   exp_q[$];

  function automatic int lowest(input logic [NS-1:0] v);
    for (int i = 0; i < NS; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [7:0] model_rdata();
    if (cpu_re && cpu_addr == IF_A) return {{(8-NS){1'b1}}, m_if};
    if (cpu_re && cpu_addr == IE_A) return m_ie;
    return 8'hFF;
  endfunction

  always @(posedge clk_5MHz) begin
    logic [NS-1:0] pend, nif;
    if (Reset) begin
      m_if = '0; m_ie = '0; m_prev = '0; m_ph = M_IDLE;
      m_req = 1'b0; m_vec = VB; m_sel = 0; m_valid = 1'b1;
    end else begin
      pend = m_if & m_ie[NS-1:0];
      nif  = m_if;
      case (m_ph)
        M_IDLE: if (ime && pend != 0) begin
          m_sel = lowest(pend);
          m_vec = 16'(int'(VB) + VS * m_sel);
          m_req = 1'b1;
          m_ph  = M_REQ;
          exp_q.push_back(m_vec);
        end
        M_REQ: if (irq_ack) begin
          nif[m_sel] = 1'b0;
          m_req = 1'b0;
          m_ph  = M_GAP;
        end else if (!pend[m_sel]) begin
          m_req = 1'b0;
          m_ph  = M_IDLE;
        end
        M_GAP: m_ph = M_IDLE;
      endcase
      if (cpu_we && cpu_addr == IF_A) nif = cpu_wdata[NS-1:0];
      if (cpu_we && cpu_addr == IE_A) m_ie = cpu_wdata;
      m_if   = nif | (src_level & ~m_prev);
      m_prev = src_level;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic req_seen = 1'b0;
  always @(negedge clk_5MHz) begin
    if (m_valid) begin
      check("irq_req", {31'd0, irq_req}, {31'd0, m_req});
      check("irq_vector", {16'd0, irq_vector}, {16'd0, m_vec});
      check("wake", {31'd0, wake}, {31'd0, |(m_if & m_ie[NS-1:0])});
      check("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, model_rdata()});
      if (irq_req === 1'b1 && !req_seen) begin
        if (exp_q.size() == 0) check("vector_queue_empty", {16'd0, irq_vector}, 32'hFFFF_FFFF);
        else check("vector_queue", {16'd0, irq_vector}, {16'd0, exp_q.pop_front()});
      end
      req_seen = (irq_req === 1'b1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_5MHz);
    #2;
    cpu_we  = 1'b0;
    cpu_re  = 1'b0;
    irq_ack = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    tick();
  endtask

  task automatic rd_check(input string name, input logic [15:0] a, input logic [7:0] exp);
    cpu_re = 1'b1; cpu_addr = a;
    @(negedge clk_5MHz);
    check(name, {24'd0, cpu_rdata}, {24'd0, exp});
    #1 cpu_re = 1'b0;
  endtask

  task automatic expect_req(input string name, input logic r, input logic [15:0] v);
    @(negedge clk_5MHz);
    check(name, {31'd0, irq_req}, {31'd0, r});
    if (r) check({name, "_vec"}, {16'd0, irq_vector}, {16'd0, v});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    repeat (3) tick();
    Reset = 1'b0;

    // Reset values
    expect_req("reset_req", 1'b0, VB);
    rd_check("reset_if", IF_A, 8'hE0);
    rd_check("reset_ie", IE_A, 8'h00);
    rd_check("reset_other", 16'h1234, 8'hFF);
    check("reset_vec", {16'd0, irq_vector}, 32'h0040);
    tick();

    // Single source, then ack
    ime = 1'b1;
    wr(IE_A, 8'h1F);
    src_level = 5'b00100;
    tick();
    rd_check("s2_if_set", IF_A, 8'hE4);
    tick();
    expect_req("s2_req", 1'b1, 16'h0050);
    irq_ack = 1'b1;
    tick();
    expect_req("s2_after_ack", 1'b0, VB);
    rd_check("s2_if_clr", IF_A, 8'hE0);
    src_level = '0;
    repeat (2) tick();

    // Coincident rises: priority, then GAP, then next vector
    src_level = 5'b10010;
    repeat (2) tick();
    expect_req("s3_first", 1'b1, 16'h0048);
    irq_ack = 1'b1;
    tick();
    expect_req("s3_gap", 1'b0, VB);
    tick();
    expect_req("s3_gap_idle", 1'b0, VB);
    tick();
    expect_req("s3_second", 1'b1, 16'h0060);
    irq_ack = 1'b1;
    tick();
    src_level = '0;
    repeat (2) tick();

    // Cancel by clearing IF while in REQ
    src_level = 5'b00001;
    repeat (2) tick();
    expect_req("s4_req", 1'b1, 16'h0040);
    wr(IF_A, 8'h00);
    tick();
    expect_req("s4_cancel", 1'b0, VB);
    repeat (3) tick();
    expect_req("s4_stay_idle", 1'b0, VB);
    src_level = '0;
    tick();

    // Rise beats same-cycle CPU clear; held level sets once
    src_level = 5'b01000;
    wr(IF_A, 8'h00);
    rd_check("s5_rise_wins", IF_A, 8'hE8);
    tick();
    expect_req("s5_req", 1'b1, 16'h0058);
    irq_ack = 1'b1;
    tick();
    repeat (100) tick();
    rd_check("s5_held_level", IF_A, 8'hE0);
    src_level = '0;
    tick();

    // wake ignores ime; ime enabling releases the request; reset mid-REQ
    ime = 1'b0;
    wr(IE_A, 8'h01);
    src_level = 5'b00001;
    repeat (2) tick();
    @(negedge clk_5MHz);
    check("s6_wake", {31'd0, wake}, 32'd1);
    check("s6_no_req", {31'd0, irq_req}, 32'd0);
    ime = 1'b1;
    tick();
    expect_req("s6_ime_req", 1'b1, 16'h0040);
    Reset = 1'b1;
    tick();
    expect_req("s6_reset_req", 1'b0, VB);
    check("s6_reset_vec", {16'd0, irq_vector}, 32'h0040);
    check("s6_reset_wake", {31'd0, wake}, 32'd0);
    rd_check("s6_reset_if", IF_A, 8'hE0);
    Reset = 1'b0;
    src_level = '0;
    tick();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) src_level = src_level ^ NS'(1 << $urandom_range(0, NS - 1));
      ime = ($urandom_range(0, 15) != 0);
      r = $urandom_range(0, 19);
      if (r == 0)      begin cpu_we = 1'b1; cpu_addr = IF_A; cpu_wdata = 8'($urandom); end
      else if (r == 1) begin cpu_we = 1'b1; cpu_addr = IE_A; cpu_wdata = 8'($urandom) | 8'h0F; end
      else if (r == 2) begin cpu_we = 1'b1; cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom); end
      else begin
        cpu_re = ($urandom_range(0, 1) == 1);
        case ($urandom_range(0, 2))
          0: cpu_addr = IF_A;
          1: cpu_addr = IE_A;
          default: cpu_addr = 16'($urandom);
        endcase
      end
      irq_ack = irq_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      Reset = ($urandom_range(0, 599) == 0);
      tick();
    end
    Reset = 1'b0;
    repeat (3) tick();

    check("vector_queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
